// File: rtl/axilite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS byte-strobed 32-bit registers; out-of-range addresses answer SLVERR.
// Latency: AW+W or AR handshake in cycle N gives BVALID / RVALID in cycle N+1.
// Backpressure: one write and one read outstanding; responses held stable until BREADY / RREADY.
module axilite_slave_regs #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int         IDX_W       = ADDR_WIDTH - 2;
    localparam int         NUM_BYTES   = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      r_idx;
    logic                  w_in_range;
    logic                  r_in_range;
    logic                  wr_hs;
    logic                  rd_hs;
    logic [DATA_WIDTH-1:0] rd_word;

    // PROT and the byte offset inside a word carry no meaning for this bank
    logic unused_bits;
    assign unused_bits = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    assign w_idx      = AWADDR[ADDR_WIDTH-1:2];
    assign r_idx      = ARADDR[ADDR_WIDTH-1:2];
    assign w_in_range = {1'b0, w_idx} < (IDX_W+1)'(NUM_REGS);
    assign r_in_range = {1'b0, r_idx} < (IDX_W+1)'(NUM_REGS);

    assign wr_hs = AWVALID && WVALID && (w_state == W_IDLE);
    assign rd_hs = ARVALID && (r_state == R_IDLE);

    // ---------------- write channel ----------------

    // Write FSM state register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_nxt;
        end
    end

    // Write FSM next state: accept AW+W together, wait for BREADY
    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (AWVALID && WVALID) w_state_nxt = W_RESP;
            W_RESP:  if (BREADY)            w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM outputs: both readies assert together so AW and W never split
    always_comb begin
        AWREADY = (w_state == W_IDLE) && AWVALID && WVALID;
        WREADY  = (w_state == W_IDLE) && AWVALID && WVALID;
        BVALID  = (w_state == W_RESP);
    end

    // Write response code captured at the handshake, held through W_RESP
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            BRESP <= RESP_OKAY;
        end else if (wr_hs) begin
            BRESP <= w_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Register storage with per-byte strobes; out-of-range indices match no entry
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hs) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int k = 0; k < NUM_BYTES; k++) begin
                    if (w_idx == IDX_W'(i) && WSTRB[k]) begin
                        regs[i][8*k +: 8] <= WDATA[8*k +: 8];
                    end
                end
            end
        end
    end

    // ---------------- read channel ----------------

    // Read mux; out-of-range indices fall through to zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                rd_word = regs[i];
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_nxt;
        end
    end

    // Read FSM next state: accept AR when idle, wait for RREADY
    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ARVALID) r_state_nxt = R_DATA;
            R_DATA:  if (RREADY)  r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM outputs: ARREADY is purely state-derived
    always_comb begin
        ARREADY = (r_state == R_IDLE);
        RVALID  = (r_state == R_DATA);
    end

    // Read data/response captured at the AR handshake; a later write cannot disturb it
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            RDATA <= '0;
            RRESP <= RESP_OKAY;
        end else if (rd_hs) begin
            RDATA <= r_in_range ? rd_word : '0;
            RRESP <= r_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

endmodule

// File: doc/axilite_slave_regs.md
Name: axilite_slave_regs

Overview:
AXI4-Lite slave register bank. It is the DUT whose bus traffic the monitors capture and the scoreboard's predictor/register-bank model checks.
- Holds NUM_REGS word registers.
- Supports byte-strobed writes.
- Returns SLVERR for out-of-range addresses.
- One outstanding write and one outstanding read at a time; the two channels are fully independent.

Parameters:
ADDR_WIDTH, 8, byte-address width of AWADDR/ARADDR
DATA_WIDTH, 32, data width; only 32 is supported (4 strobe bits)
NUM_REGS, 16, number of registers; must be 1..2**(ADDR_WIDTH-2)

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESETn  in  1  asynchronous active-low reset
AWADDR  in  ADDR_WIDTH  write byte address
AWPROT  in  3  ignored
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte strobes
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_WIDTH  read byte address
ARPROT  in  3  ignored
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready

Behaviour:
- Reset (ARESETn low, async):
  - all registers = 0
  - BVALID, RVALID = 0; RDATA = 0; BRESP, RRESP = 2'b00
  - both FSMs go to IDLE
  - any in-flight transaction is dropped and no response is issued after reset
- Decode: index = addr[ADDR_WIDTH-1:2]; addr[1:0] are ignored. index < NUM_REGS gives OKAY (2'b00), otherwise SLVERR (2'b10).
- Write FSM, states W_IDLE and W_RESP:
  - AWREADY = WREADY = (state==W_IDLE) && AWVALID && WVALID, combinational. The two readies always assert together, so AW and W are accepted in the same cycle; if only one channel is valid, neither is accepted.
  - On handshake: if in range, reg[index] byte k <= WDATA byte k for each WSTRB[k]=1; out of range, nothing is written. BRESP is set, BVALID <= 1, go to W_RESP.
  - W_RESP: BVALID and BRESP are held stable until BVALID && BREADY, then BVALID <= 0 and return to W_IDLE. No new AW/W is accepted while in W_RESP.
  - Latency: handshake in cycle N gives BVALID in cycle N+1; BREADY held high gives a back-to-back write every 2 cycles.
  - WSTRB = 0 leaves the register unchanged and still returns OKAY.
- Read FSM, states R_IDLE and R_DATA:
  - ARREADY = (state==R_IDLE), registered/state-derived, so it may be high with ARVALID low.
  - On ARVALID && ARREADY: RDATA <= in range ? reg[index] : 0; RRESP set; RVALID <= 1; go to R_DATA.
  - R_DATA: ARREADY = 0; RDATA and RRESP are held stable until RVALID && RREADY, then return to R_IDLE.
  - Latency: AR handshake in cycle N gives RVALID in cycle N+1.
- Read and write to the same register handshaking in the same cycle: the read returns the pre-write value; the write commits at that edge.
- A write that lands while a read response is pending does not alter the already-captured RDATA.
- Outputs never change while VALID=1 and READY=0.

Test Plan:
- Reset, then read idx 0..15 -> every RDATA = 0x00000000, RRESP = 00; ARREADY high one cycle after reset release.
- Write 0xDEADBEEF to 0x08 with WSTRB=4'hF, then WSTRB=4'b0101 with data 0x11223344, then read 0x08 -> BRESP=00 both times, BVALID 1 cycle after handshake, RDATA = 0xDE22BE44.
- Write 0xA5A5A5A5 to 0x40 (index 16, out of range) -> BRESP=10, registers unchanged; read 0x40 -> RDATA=0, RRESP=10.
- Hold BREADY/RREADY low 5 cycles after responses -> BVALID/RVALID, BRESP/RRESP and RDATA stay stable; AWREADY/WREADY/ARREADY stay 0; the next transaction is accepted only after the ready is asserted.
- AWVALID high with WVALID delayed 3 cycles -> no handshake until WVALID rises, then AWREADY=WREADY=1 in the same cycle. Same-cycle AR and AW/W to 0x04 (old 0x1, new 0x2) -> RDATA=0x1, and a following read returns 0x2.
- Assert ARESETn low while BVALID=1 and RVALID=1 -> both drop to 0 immediately (async); after release no stale response appears and all registers read 0.
